mean_seq_ctrl: RTL and testbench
================================

Name: mean_seq_ctrl

Overview:
- Sequencer for the frame-mean engine.
- Per request, streams an offset list (base + i*stride) into the engine's configuration port with valid/ready/last.
- Then collects exactly RESULT_NUM mean results, forwards each with its index, and pulses done.
- Sits between the audio control FSM and the mean engine; owns the engine for the whole job.

Parameters:
- DATA_WIDTH, 9, width of a mean result.
- FRAME_WIDTH, 9, width of cfg offsets and of frame_len.
- RESULT_NUM, 31, number of results per job.
- TIMEOUT_CYCLES, 4096, watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  job request pulse; sampled only in IDLE.
- frame_len  in  FRAME_WIDTH  number of cfg entries N; latched on an accepted start.
- base  in  FRAME_WIDTH  first offset; latched on an accepted start.
- stride  in  FRAME_WIDTH  offset increment; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  one-cycle pulse on a rejected start, unexpected result or timeout.
- m_cfg_valid  out  1  to engine cfg_valid.
- m_cfg_data  out  FRAME_WIDTH  to engine cfg_data.
- m_cfg_last  out  1  to engine cfg_last.
- m_ready  in  1  from engine o_ready.
- m_valid  in  1  from engine o_valid.
- m_data  in  DATA_WIDTH  from engine o_data (signed).
- res_valid  out  1  result strobe.
- res_data  out  DATA_WIDTH  result value.
- res_idx  out  5  result index, 0..RESULT_NUM-1.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-job aborts immediately with no done pulse.
- States: IDLE, WAIT_RDY, CFG, WAIT_RES, FINISH.
- IDLE:
  - start=1 with frame_len!=0: latch frame_len/base/stride, clear i and res_cnt, go to WAIT_RDY.
  - start=1 with frame_len==0: err pulse next cycle, stay IDLE.
- WAIT_RDY: go to CFG on the first cycle m_ready=1.
- CFG:
  - m_cfg_valid = (state==CFG) & m_ready, combinational, so valid is never high without ready. This is required because the engine advances its write counter on valid alone.
  - m_cfg_data = base + i*stride, truncated to FRAME_WIDTH (mod 2^FRAME_WIDTH wrap). Registered; updated on each beat.
  - A beat is valid&ready; each beat increments i.
  - m_cfg_last = m_cfg_valid & (i==N-1).
  - After the last beat, go to WAIT_RES.
  - m_ready dropping mid-list stalls: i and data hold, no beat.
- WAIT_RES:
  - Each m_valid=1 cycle: next cycle res_valid=1, res_data=m_data, res_idx=res_cnt; res_cnt increments. Latency is 1 cycle. There is no backpressure; the consumer must accept every cycle.
  - When res_cnt reaches RESULT_NUM, go to FINISH.
- FINISH: done=1 for one cycle, busy falls in the same cycle, return to IDLE.
- m_valid outside WAIT_RES: ignored for res_valid, err pulse.
- start while busy: ignored, no err.
- N=1: a single beat with valid and last both high.
- N=2^FRAME_WIDTH-1 (511): i counter must not overflow.
- stride=0: all offsets equal base.

Optional Feature:
- MEAN_SEQ_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_RDY, CFG and WAIT_RES, clearing on every beat or result.
  - When it reaches TIMEOUT_CYCLES: err pulse, return to IDLE without done, m_cfg_valid forced 0.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- start, frame_len=4, base=10, stride=31, m_ready constant 1 -> beats carry 10,41,72,103 on consecutive cycles; last only on 103; then 31 m_valid pulses with m_data=i -> res_idx 0..30, res_data matches one cycle later, done once, busy low afterwards.
- frame_len=3, m_ready toggled 1,0,0,1,1 -> no m_cfg_valid while ready=0; data sequence unchanged; exactly 3 beats.
- base=500, stride=20, frame_len=2 -> offsets 500, 8 (wrap mod 512).
- start with frame_len=0 -> err pulse, busy stays 0; start during CFG -> ignored; m_valid pulse in IDLE -> err, no res_valid.
- rst asserted after 10 of 31 results -> all outputs 0 immediately; a new job completes normally with res_idx restarting at 0.
- With MEAN_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, m_ready held 0 after start -> err on the 16th idle cycle, return to IDLE, no done. Without the macro -> busy stays 1.

Source files
------------

// File: rtl/mean_seq_ctrl_if.sv
// Link between the mean sequencer (master) and the frame-mean engine (slave):
// offset stream towards the engine, mean results back from it.
interface mean_seq_ctrl_if #(
    parameter int DATA_WIDTH  = 9,
    parameter int FRAME_WIDTH = 9
);
    logic                   m_cfg_valid;
    logic [FRAME_WIDTH-1:0] m_cfg_data;
    logic                   m_cfg_last;
    logic                   m_ready;
    logic                   m_valid;
    logic [DATA_WIDTH-1:0]  m_data;

    modport master (
        output m_cfg_valid, m_cfg_data, m_cfg_last,
        input  m_ready, m_valid, m_data
    );

    modport slave (
        input  m_cfg_valid, m_cfg_data, m_cfg_last,
        output m_ready, m_valid, m_data
    );
endinterface

// File: rtl/mean_seq_ctrl.sv
// Frame-mean job sequencer: streams base+i*stride offsets to the engine, then
// forwards RESULT_NUM indexed results. Optional watchdog: MEAN_SEQ_TIMEOUT_EN.
module mean_seq_ctrl #(
    parameter int DATA_WIDTH     = 9,
    parameter int FRAME_WIDTH    = 9,
    parameter int RESULT_NUM     = 31,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [FRAME_WIDTH-1:0] frame_len,
    input  logic [FRAME_WIDTH-1:0] base,
    input  logic [FRAME_WIDTH-1:0] stride,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    mean_seq_ctrl_if.master        eng,
    output logic                   res_valid,
    output logic [DATA_WIDTH-1:0]  res_data,
    output logic [4:0]             res_idx
);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, CFG, WAIT_RES, FINISH} state_t;

    localparam logic [FRAME_WIDTH-1:0] ONE_F    = FRAME_WIDTH'(1);
    localparam logic [FRAME_WIDTH-1:0] ZERO_F   = FRAME_WIDTH'(0);
    localparam logic [4:0]             LAST_IDX = 5'(RESULT_NUM - 1);

    state_t                 state_r;
    logic [FRAME_WIDTH-1:0] len_r;
    logic [FRAME_WIDTH-1:0] stride_r;
    logic [FRAME_WIDTH-1:0] i_r;
    logic [FRAME_WIDTH-1:0] cfg_data_r;
    logic [4:0]             res_cnt_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   err_r;
    logic                   res_valid_r;
    logic [DATA_WIDTH-1:0]  res_data_r;
    logic [4:0]             res_idx_r;
    logic [FRAME_WIDTH-1:0] len_m1_s;
    logic                   cfg_valid_s;
    logic                   cfg_last_s;
    logic                   to_hit_s;

    assign len_m1_s = len_r - ONE_F;

`ifdef MEAN_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_r;
    logic            active_s;
    logic            progress_s;

    // A beat in CFG is exactly "ready while in CFG", so progress never depends on cfg_valid_s.
    assign active_s   = (state_r == WAIT_RDY) || (state_r == CFG) || (state_r == WAIT_RES);
    assign progress_s = ((state_r == CFG) && eng.m_ready) || ((state_r == WAIT_RES) && eng.m_valid);
    assign to_hit_s   = active_s && !progress_s && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts stalled cycles of an active job, restarts on any beat or result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= TO_W'(0);
        end else if (!active_s || progress_s || to_hit_s) begin
            to_cnt_r <= TO_W'(0);
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end
`else
    assign to_hit_s = 1'b0;
`endif

    // Valid is combinational on ready: the engine advances its write pointer on valid alone.
    always_comb begin
        cfg_valid_s = 1'b0;
        cfg_last_s  = 1'b0;
        if ((state_r == CFG) && !to_hit_s) begin
            cfg_valid_s = eng.m_ready;
            cfg_last_s  = eng.m_ready & (i_r == len_m1_s);
        end else begin
            cfg_valid_s = 1'b0;
            cfg_last_s  = 1'b0;
        end
    end

    // Job sequencing FSM with registered status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            len_r       <= ZERO_F;
            stride_r    <= ZERO_F;
            i_r         <= ZERO_F;
            cfg_data_r  <= ZERO_F;
            res_cnt_r   <= 5'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= {DATA_WIDTH{1'b0}};
            res_idx_r   <= 5'd0;
        end else begin
            done_r      <= 1'b0;
            err_r       <= (state_r != WAIT_RES) && eng.m_valid;
            res_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && (frame_len != ZERO_F)) begin
                        len_r      <= frame_len;
                        stride_r   <= stride;
                        cfg_data_r <= base;
                        i_r        <= ZERO_F;
                        res_cnt_r  <= 5'd0;
                        busy_r     <= 1'b1;
                        state_r    <= WAIT_RDY;
                    end else if (start) begin
                        err_r <= 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (eng.m_ready) begin
                        state_r <= CFG;
                    end
                end
                CFG: begin
                    // Running sum keeps base + i*stride (mod 2^FRAME_WIDTH) without a multiplier.
                    if (cfg_valid_s) begin
                        cfg_data_r <= cfg_data_r + stride_r;
                        if (i_r == len_m1_s) begin
                            state_r <= WAIT_RES;
                        end else begin
                            i_r <= i_r + ONE_F;
                        end
                    end
                end
                WAIT_RES: begin
                    if (eng.m_valid) begin
                        res_valid_r <= 1'b1;
                        res_data_r  <= eng.m_data;
                        res_idx_r   <= res_cnt_r;
                        res_cnt_r   <= res_cnt_r + 5'd1;
                        if (res_cnt_r == LAST_IDX) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            if (to_hit_s) begin
                err_r   <= 1'b1;
                busy_r  <= 1'b0;
                state_r <= IDLE;
            end
        end
    end

    assign eng.m_cfg_valid = cfg_valid_s;
    assign eng.m_cfg_data  = cfg_data_r;
    assign eng.m_cfg_last  = cfg_last_s;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;
    assign res_valid       = res_valid_r;
    assign res_data        = res_data_r;
    assign res_idx         = res_idx_r;

endmodule

// File: tb/tb_mean_seq_ctrl.sv
// Scoreboard bench for mean_seq_ctrl: expected offsets/results are queued as
// stimulus is driven and popped when the DUT emits beats/results.
module tb_mean_seq_ctrl;
    localparam int DW = 9;
    localparam int FW = 9;
    localparam int RN = 31;
`ifdef MEAN_SEQ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FW-1:0] frame_len;
    logic [FW-1:0] base;
    logic [FW-1:0] stride;
    logic          busy;
    logic          done;
    logic          err;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [4:0]    res_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [FW:0]   cfg_q[$];
    logic [DW+4:0] res_q[$];

    mean_seq_ctrl_if #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW)) eng_if ();

    mean_seq_ctrl #(
        .DATA_WIDTH(DW), .FRAME_WIDTH(FW), .RESULT_NUM(RN), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .base(base),
        .stride(stride), .busy(busy), .done(done), .err(err), .eng(eng_if),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; frame_len = '0; base = '0; stride = '0;
        eng_if.m_ready = 1'b0; eng_if.m_valid = 1'b0; eng_if.m_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the start was sampled.
    task automatic go(input int l, input int b, input int s);
        start = 1'b1; frame_len = FW'(l); base = FW'(b); stride = FW'(s);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_cfg(input int l, input int b, input int s);
        cfg_q.delete();
        for (int k = 0; k < l; k++) begin
            int v;
            v = (b + k * s) % (1 << FW);
            cfg_q.push_back({(k == l - 1) ? 1'b1 : 1'b0, FW'(v)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; frame_len = '0; base = '0; stride = '0;
        eng_if.m_ready = 1'b1; eng_if.m_valid = 1'b0; eng_if.m_data = '0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got busy/done/err=%b, want 000", {busy, done, err});
        end
        n_checks++;
        if ({eng_if.m_cfg_valid, eng_if.m_cfg_last, eng_if.m_cfg_data} !== 11'd0) begin
            n_fail++; $display("FAIL reset_cfg: got %b, want 0", {eng_if.m_cfg_valid, eng_if.m_cfg_last, eng_if.m_cfg_data});
        end
        n_checks++;
        if ({res_valid, res_idx, res_data} !== 15'd0) begin
            n_fail++; $display("FAIL reset_res: got %h, want 0", {res_valid, res_idx, res_data});
        end
        rst = 1'b0;
    endtask

    // Full job; abort_at>=0 applies reset after that many results instead of finishing.
    task automatic test_job(input int l, input int b, input int s, input int abort_at);
        int beats = 0, fed = 0, got = 0, dones = 0, errs = 0, first_c = -1, last_c = -1;
        bit fin = 1'b0, busy_at_done = 1'b1;
        logic [FW:0]   ec;
        logic [DW+4:0] er;
        logic [DW-1:0] d;
        push_cfg(l, b, s);
        res_q.delete();
        eng_if.m_ready = 1'b1; eng_if.m_valid = 1'b0;
        go(l, b, s);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_start: got %b, want 1", busy);
        end
        for (int c = 0; c < l + RN + 20 && !fin && !(abort_at >= 0 && got >= abort_at); c++) begin
            if (beats == l && fed < RN) begin
                d = DW'(fed * 13 + l);
                eng_if.m_valid = 1'b1; eng_if.m_data = d;
                res_q.push_back({5'(fed), d});
                fed++;
            end else begin
                eng_if.m_valid = 1'b0;
            end
            @(negedge clk);
            if (eng_if.m_cfg_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c; beats++;
                n_checks++;
                if (cfg_q.size() == 0) begin
                    n_fail++; $display("FAIL cfg_extra: got beat data=%0d, want none", eng_if.m_cfg_data);
                end else begin
                    ec = cfg_q.pop_front();
                    if ({eng_if.m_cfg_last, eng_if.m_cfg_data} !== ec) begin
                        n_fail++; $display("FAIL cfg_beat: got last=%b data=%0d, want last=%b data=%0d",
                                           eng_if.m_cfg_last, eng_if.m_cfg_data, ec[FW], ec[FW-1:0]);
                    end
                end
            end
            if (res_valid) begin
                got++; n_checks++;
                if (res_q.size() == 0) begin
                    n_fail++; $display("FAIL res_extra: got idx=%0d, want none", res_idx);
                end else begin
                    er = res_q.pop_front();
                    if ({res_idx, res_data} !== er) begin
                        n_fail++; $display("FAIL res_item: got idx=%0d data=%0d, want idx=%0d data=%0d",
                                           res_idx, res_data, er[DW+4:DW], er[DW-1:0]);
                    end
                end
            end
            if (err) errs++;
            if (done) begin dones++; fin = 1'b1; busy_at_done = busy; end
            @(posedge clk); #1;
        end
        eng_if.m_valid = 1'b0;
        n_checks++;
        if (errs !== 0) begin
            n_fail++; $display("FAIL job_err: got %0d err pulses, want 0", errs);
        end
        if (abort_at >= 0) begin
            rst = 1'b1; #1;
            n_checks++;
            if (got !== abort_at) begin
                n_fail++; $display("FAIL abort_reached: got %0d results, want %0d", got, abort_at);
            end
            n_checks++;
            if ({busy, done, err, eng_if.m_cfg_valid, eng_if.m_cfg_last, eng_if.m_cfg_data,
                 res_valid, res_idx, res_data} !== 29'd0) begin
                n_fail++; $display("FAIL abort_outputs: got busy=%b res_valid=%b idx=%0d data=%0d cfg=%0d, want all 0",
                                   busy, res_valid, res_idx, res_data, eng_if.m_cfg_data);
            end
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            n_checks++;
            if (beats !== l || (last_c - first_c) !== l - 1) begin
                n_fail++; $display("FAIL cfg_burst: got %0d beats over %0d cycles, want %0d consecutive",
                                   beats, last_c - first_c + 1, l);
            end
            n_checks++;
            if (got !== RN || res_q.size() !== 0) begin
                n_fail++; $display("FAIL res_count: got %0d results, want %0d", got, RN);
            end
            n_checks++;
            if (dones !== 1 || busy_at_done !== 1'b0) begin
                n_fail++; $display("FAIL done_pulse: got dones=%0d busy_at_done=%b, want 1 and 0", dones, busy_at_done);
            end
            @(negedge clk);
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++; $display("FAIL after_done: got done/busy=%b, want 00", {done, busy});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic pat[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int beats = 0, bad = 0;
        logic [FW:0] ec;
        do_reset();
        push_cfg(3, 7, 5);
        eng_if.m_ready = 1'b1;
        go(3, 7, 5);
        for (int c = 0; c < 12; c++) begin
            eng_if.m_ready = pat[c];
            @(negedge clk);
            if (eng_if.m_cfg_valid && !eng_if.m_ready) bad++;
            if (eng_if.m_cfg_valid) begin
                beats++; n_checks++;
                if (cfg_q.size() == 0) begin
                    n_fail++; $display("FAIL stall_extra: got beat data=%0d, want none", eng_if.m_cfg_data);
                end else begin
                    ec = cfg_q.pop_front();
                    if ({eng_if.m_cfg_last, eng_if.m_cfg_data} !== ec) begin
                        n_fail++; $display("FAIL stall_beat: got last=%b data=%0d, want last=%b data=%0d",
                                           eng_if.m_cfg_last, eng_if.m_cfg_data, ec[FW], ec[FW-1:0]);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad !== 0 || beats !== 3) begin
            n_fail++; $display("FAIL stall_count: got beats=%0d valid_without_ready=%0d, want 3 and 0", beats, bad);
        end
    endtask

    task automatic test_offsets();
        int cases[4][3] = '{'{2, 500, 20}, '{1, 77, 0}, '{4, 200, 0}, '{511, 3, 1}};
        logic [FW:0] ec;
        for (int t = 0; t < 4; t++) begin
            int beats = 0;
            do_reset();
            push_cfg(cases[t][0], cases[t][1], cases[t][2]);
            eng_if.m_ready = 1'b1;
            go(cases[t][0], cases[t][1], cases[t][2]);
            for (int c = 0; c < cases[t][0] + 10; c++) begin
                @(negedge clk);
                if (eng_if.m_cfg_valid) begin
                    beats++; n_checks++;
                    if (cfg_q.size() == 0) begin
                        n_fail++; $display("FAIL off_extra: case %0d got data=%0d, want none", t, eng_if.m_cfg_data);
                    end else begin
                        ec = cfg_q.pop_front();
                        if ({eng_if.m_cfg_last, eng_if.m_cfg_data} !== ec) begin
                            n_fail++; $display("FAIL off_beat: case %0d got last=%b data=%0d, want last=%b data=%0d",
                                               t, eng_if.m_cfg_last, eng_if.m_cfg_data, ec[FW], ec[FW-1:0]);
                        end
                    end
                end
                @(posedge clk); #1;
            end
            n_checks++;
            if (beats !== cases[t][0]) begin
                n_fail++; $display("FAIL off_count: case %0d got %0d beats, want %0d", t, beats, cases[t][0]);
            end
        end
    endtask

    task automatic test_errors();
        int beats = 0, errs = 0;
        logic [FW:0] ec;
        do_reset();
        go(0, 9, 1);
        @(negedge clk);
        n_checks++;
        if ({err, busy} !== 2'b10) begin
            n_fail++; $display("FAIL zero_len_err: got err/busy=%b, want 10", {err, busy});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({err, busy} !== 2'b00) begin
            n_fail++; $display("FAIL zero_len_idle: got err/busy=%b, want 00", {err, busy});
        end
        @(posedge clk); #1;
        eng_if.m_valid = 1'b1; eng_if.m_data = 9'h055;
        @(posedge clk); #1;
        eng_if.m_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({err, res_valid} !== 2'b10) begin
            n_fail++; $display("FAIL idle_mvalid: got err/res_valid=%b, want 10", {err, res_valid});
        end
        @(posedge clk); #1;
        push_cfg(3, 10, 1);
        eng_if.m_ready = 1'b1;
        go(3, 10, 1);
        for (int c = 0; c < 8; c++) begin
            start = (c < 3) ? 1'b1 : 1'b0;
            frame_len = 9'd5; base = 9'd200; stride = 9'd9;
            @(negedge clk);
            if (err) errs++;
            if (eng_if.m_cfg_valid) begin
                beats++; n_checks++;
                ec = (cfg_q.size() != 0) ? cfg_q.pop_front() : '1;
                if ({eng_if.m_cfg_last, eng_if.m_cfg_data} !== ec) begin
                    n_fail++; $display("FAIL busy_start_beat: got last=%b data=%0d, want last=%b data=%0d",
                                       eng_if.m_cfg_last, eng_if.m_cfg_data, ec[FW], ec[FW-1:0]);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (beats !== 3 || errs !== 0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_start: got beats=%0d errs=%0d busy=%b, want 3 0 1", beats, errs, busy);
        end
    endtask

    task automatic test_timeout();
        int errs = 0, dones = 0;
        do_reset();
        eng_if.m_ready = 1'b0;
        go(2, 0, 1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (err) errs++;
            if (done) dones++;
            @(posedge clk); #1;
        end
        n_checks++;
`ifdef MEAN_SEQ_TIMEOUT_EN
        if (errs !== 1 || dones !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout: got errs=%0d dones=%0d busy=%b, want 1 0 0", errs, dones, busy);
        end
`else
        if (errs !== 0 || dones !== 0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL no_timeout: got errs=%0d dones=%0d busy=%b, want 0 0 1", errs, dones, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        do_reset();
        test_job(4, 10, 31, -1);
        test_job(2, 3, 1, 10);
        test_job(5, 0, 100, -1);
        test_stall();
        test_offsets();
        test_errors();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
